arcade_input_mapper: RTL

ARCADE_INPUT_MAPPER -- requirements
Module: arcade_input_mapper

---
 rtl/arcade_input_mapper.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/arcade_input_mapper.sv
`default_nettype none
// arcade_input_mapper: merges PS/2 keys and joysticks into per-player controls
// with rotation, opposite-direction cancel and a one-shot coin pulse. Rev 1.0
module arcade_input_mapper #(
  parameter int NUM_PLAYERS = 2,
  parameter int COIN_CYCLES = 2457600
) (
  input  logic                      I_CLK,
  input  logic                      I_RESETn,
  input  logic [10:0]               I_PS2_KEY,
  input  logic [16*NUM_PLAYERS-1:0] I_JOY,
  input  logic [1:0]                I_ROT,
  input  logic                      I_SHARE,
  output logic [4*NUM_PLAYERS-1:0]  O_DIRn,
  output logic [NUM_PLAYERS-1:0]    O_FIREn,
  output logic [NUM_PLAYERS-1:0]    O_STARTn,
  output logic                      O_COINn
);

  localparam int CW = (COIN_CYCLES > 1) ? $clog2(COIN_CYCLES) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] PULSE = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  logic       tog_prev;
  logic       primed;
  logic       key_up, key_down, key_left, key_right, key_fire, key_coin;
  logic [1:0] key_start;
  logic       kb_event;

  // primed keeps the first post-reset toggle sample from looking like an event
  assign kb_event = primed && (I_PS2_KEY[10] != tog_prev);

  always_ff @(posedge I_CLK or negedge I_RESETn) begin
    if (!I_RESETn) begin
      tog_prev  <= 1'b0;
      primed    <= 1'b0;
      key_up    <= 1'b0;
      key_down  <= 1'b0;
      key_left  <= 1'b0;
      key_right <= 1'b0;
      key_fire  <= 1'b0;
      key_coin  <= 1'b0;
      key_start <= 2'b00;
    end else begin
      tog_prev <= I_PS2_KEY[10];
      primed   <= 1'b1;
      if (kb_event) begin
        case (I_PS2_KEY[7:0])
          8'h75:   key_up    <= I_PS2_KEY[9];
          8'h72:   key_down  <= I_PS2_KEY[9];
          8'h6B:   key_left  <= I_PS2_KEY[9];
          8'h74:   key_right <= I_PS2_KEY[9];
          default: ;
        endcase
        case (I_PS2_KEY[8:0])
          9'h029, 9'h014: key_fire <= I_PS2_KEY[9];
          9'h005:  key_start[0] <= I_PS2_KEY[9];
          9'h006:  if (NUM_PLAYERS >= 2) key_start[1] <= I_PS2_KEY[9];
          9'h004:  key_coin <= I_PS2_KEY[9];
          default: ;
        endcase
      end
    end
  end

  // raw[p] = {fire, up, down, left, right}
  logic [4:0] raw [NUM_PLAYERS];
  logic [4:0] raw_or;
  logic [1:0] joy_start_any;

  always_comb begin
    raw_or        = '0;
    joy_start_any = '0;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      raw[p] = I_JOY[16*p +: 5];
      if (p == 0) raw[p] = raw[p] | {key_fire, key_up, key_down, key_left, key_right};
      raw_or        = raw_or | raw[p];
      joy_start_any = joy_start_any | I_JOY[16*p+5 +: 2];
    end
  end

  logic [NUM_PLAYERS-1:0] start_now;

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
    logic [4:0] m;
    logic       ru, rd, rl, rr;
    logic       unused_joy_hi;

    assign unused_joy_hi = ^I_JOY[16*p+7 +: 9];

    if (p < 2) begin : g_shared_start
      assign start_now[p] = key_start[p] | joy_start_any[p];
    end else begin : g_own_start
      assign start_now[p] = I_JOY[16*p+5];
    end

    always_comb begin
      m = I_SHARE ? raw_or : raw[p];
      case (I_ROT)
        2'd0:    {ru, rd, rl, rr} = m[3:0];
        2'd1:    {ru, rd, rl, rr} = {m[1], m[0], m[2], m[3]};
        2'd2:    {ru, rd, rl, rr} = {m[0], m[1], m[3], m[2]};
        default: {ru, rd, rl, rr} = {m[2], m[3], m[0], m[1]};
      endcase
    end

    always_ff @(posedge I_CLK or negedge I_RESETn) begin
      if (!I_RESETn) begin
        O_DIRn[4*p +: 4] <= 4'hF;
        O_FIREn[p]       <= 1'b1;
        O_STARTn[p]      <= 1'b1;
      end else begin
        O_DIRn[4*p +: 4] <= ~{ru & ~rd, rd & ~ru, rl & ~rr, rr & ~rl};
        O_FIREn[p]       <= ~m[4];
        O_STARTn[p]      <= ~start_now[p];
      end
    end
  end

  logic          coin_req;
  logic          req_prev;
  logic [1:0]    state;
  logic [CW-1:0] coin_cnt;

  assign coin_req = key_coin | (|start_now);

  // req_prev resets high so a request still held across reset is not an edge
  always_ff @(posedge I_CLK or negedge I_RESETn) begin
    if (!I_RESETn) begin
      state    <= IDLE;
      coin_cnt <= '0;
      req_prev <= 1'b1;
    end else begin
      req_prev <= coin_req;
      case (state)
        IDLE: begin
          if (coin_req && !req_prev) begin
            state    <= PULSE;
            coin_cnt <= CW'(COIN_CYCLES - 1);
          end
        end
        PULSE: begin
          if (coin_cnt == '0) state <= HOLD;
          else coin_cnt <= coin_cnt - 1'b1;
        end
        HOLD: begin
          if (!coin_req) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign O_COINn = (state != PULSE);

endmodule
`default_nettype wire
